eco32f_pipe_ctrl: RTL and testbench

Pipeline control for the eco32f core. It consumes the unit busy signals (fetch, ALU serial divider, data memory), the taken-branch indication from EX and the exception and interrupt requests. From these it produces the per-stage stall and flush signals that the EX/ALU block and the other stages obey. It also generates PC redirects for reset, taken branches and exception entry, and captures the EPC and cause of each exception.

---
 rtl/eco32f_pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_eco32f_pipe_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/eco32f_pipe_ctrl.sv
// Pipeline control for eco32f: per-stage stall/flush, PC redirects and
// exception entry sequencing (RESET -> RUN -> DRAIN -> VECTOR).
module eco32f_pipe_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hE0000000,
  parameter logic [31:0] EXC_VECTOR = 32'hE0000004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_busy,
  input  logic        alu_stall,
  input  logic        mem_busy,
  input  logic        id_hazard,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic [31:0] ex_pc,
  input  logic        ex_exc_div_by_zero,
  input  logic        ex_exc_illegal,
  input  logic        mem_exc_bus,
  input  logic [31:0] mem_pc,
  input  logic        irq,
  input  logic [3:0]  irq_num,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        exc_taken,
  output logic [31:0] epc,
  output logic [4:0]  exc_cause
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_VECTOR = 2'd3
  } state_t;

  localparam logic [4:0] CAUSE_BUS     = 5'd16;
  localparam logic [4:0] CAUSE_ILLEGAL = 5'd17;
  localparam logic [4:0] CAUSE_DIVIDE  = 5'd19;

  state_t      state_reg, state_next;
  logic [31:0] epc_reg, epc_next;
  logic [4:0]  cause_reg, cause_next;

  assign mem_stall = mem_busy;
  assign ex_stall  = mem_stall | alu_stall;
  assign id_stall  = ex_stall | id_hazard;
  assign if_stall  = id_stall | if_busy;

  assign epc       = epc_reg;
  assign exc_cause = cause_reg;

  // Event outputs are decided from the current inputs so a redirect or
  // kill lands in the same cycle the triggering instruction sits in EX/MEM.
  always_comb begin
    state_next  = state_reg;
    epc_next    = epc_reg;
    cause_next  = cause_reg;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    mem_flush   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    exc_taken   = 1'b0;
    if (!rst) begin
      state_next = ST_RESET;
      if_flush   = 1'b1;
      id_flush   = 1'b1;
      ex_flush   = 1'b1;
      mem_flush  = 1'b1;
    end else begin
      case (state_reg)
        ST_RESET: begin
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          ex_flush    = 1'b1;
          mem_flush   = 1'b1;
          redirect    = 1'b1;
          redirect_pc = RESET_PC;
          state_next  = ST_RUN;
        end
        ST_RUN: begin
          if (mem_exc_bus && !mem_stall) begin
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            ex_flush   = 1'b1;
            mem_flush  = 1'b1;
            exc_taken  = 1'b1;
            epc_next   = mem_pc;
            cause_next = CAUSE_BUS;
            state_next = ST_DRAIN;
          end else if ((ex_exc_illegal || ex_exc_div_by_zero) && !ex_stall) begin
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            ex_flush   = 1'b1;
            exc_taken  = 1'b1;
            epc_next   = ex_pc;
            cause_next = ex_exc_illegal ? CAUSE_ILLEGAL : CAUSE_DIVIDE;
            state_next = ST_DRAIN;
          end else if (ex_branch_taken && !ex_stall) begin
            // The branch itself proceeds; only the younger wrong-path slots die.
            if_flush    = 1'b1;
            id_flush    = 1'b1;
            redirect    = 1'b1;
            redirect_pc = ex_branch_target;
          end else if (irq && !ex_stall) begin
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            ex_flush   = 1'b1;
            exc_taken  = 1'b1;
            epc_next   = ex_pc;
            cause_next = {1'b0, irq_num};
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if_flush = 1'b1;
          id_flush = 1'b1;
          ex_flush = 1'b1;
          if (!mem_stall) state_next = ST_VECTOR;
        end
        ST_VECTOR: begin
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          ex_flush    = 1'b1;
          redirect    = 1'b1;
          redirect_pc = EXC_VECTOR;
          state_next  = ST_RUN;
        end
        default: state_next = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_RESET;
      epc_reg   <= 32'h0;
      cause_reg <= 5'd0;
    end else begin
      state_reg <= state_next;
      epc_reg   <= epc_next;
      cause_reg <= cause_next;
    end
  end

endmodule

// File: tb/tb_eco32f_pipe_ctrl.sv
// Scoreboard bench for eco32f_pipe_ctrl: stimulus pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_eco32f_pipe_ctrl;

  localparam logic [31:0] RPC = 32'hE0000000;
  localparam logic [31:0] EV  = 32'hE0000004;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_busy, alu_stall, mem_busy, id_hazard;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target, ex_pc, mem_pc;
  logic        ex_exc_div_by_zero, ex_exc_illegal, mem_exc_bus, irq;
  logic [3:0]  irq_num;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        redirect, exc_taken;
  logic [31:0] redirect_pc, epc;
  logic [4:0]  exc_cause;

  typedef struct packed {
    logic [3:0]  stl;   // {if,id,ex,mem}
    logic [3:0]  fl;    // {if,id,ex,mem}
    logic        rd;
    logic [31:0] rpc;
    logic        et;
    logic [31:0] epc;
    logic [4:0]  cause;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  eco32f_pipe_ctrl dut (
    .clk(clk), .rst(rst), .if_busy(if_busy), .alu_stall(alu_stall),
    .mem_busy(mem_busy), .id_hazard(id_hazard),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_pc(ex_pc), .ex_exc_div_by_zero(ex_exc_div_by_zero),
    .ex_exc_illegal(ex_exc_illegal), .mem_exc_bus(mem_exc_bus),
    .mem_pc(mem_pc), .irq(irq), .irq_num(irq_num),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc_taken(exc_taken), .epc(epc),
    .exc_cause(exc_cause)
  );

  // Monitor: compare the DUT against the oldest pending expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.stl   = {if_stall, id_stall, ex_stall, mem_stall};
      a.fl    = {if_flush, id_flush, ex_flush, mem_flush};
      a.rd    = redirect;
      a.rpc   = redirect_pc;
      a.et    = exc_taken;
      a.epc   = epc;
      a.cause = exc_cause;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got stl=%b fl=%b rd=%b rpc=%h et=%b epc=%h cause=%0d, want stl=%b fl=%b rd=%b rpc=%h et=%b epc=%h cause=%0d",
                 n, a.stl, a.fl, a.rd, a.rpc, a.et, a.epc, a.cause,
                 e.stl, e.fl, e.rd, e.rpc, e.et, e.epc, e.cause);
      end else begin
        $display("[TB] ok %s stl=%b fl=%b rd=%b rpc=%h et=%b epc=%h cause=%0d",
                 n, a.stl, a.fl, a.rd, a.rpc, a.et, a.epc, a.cause);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; if_busy = 1'b0; alu_stall = 1'b0; mem_busy = 1'b0;
    id_hazard = 1'b0; ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
    ex_pc = 32'h0; mem_pc = 32'h0; ex_exc_div_by_zero = 1'b0;
    ex_exc_illegal = 1'b0; mem_exc_bus = 1'b0; irq = 1'b0; irq_num = 4'd0;
  endtask

  task automatic expect_out(input string n, input logic [3:0] stl, input logic [3:0] fl,
                            input logic rd, input logic [31:0] rpc, input logic et,
                            input logic [31:0] e_epc, input logic [4:0] cause);
    exp_t e;
    e.stl = stl; e.fl = fl; e.rd = rd; e.rpc = rpc; e.et = et;
    e.epc = e_epc; e.cause = cause;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset hold and release
    if_busy = 1'b1;
    expect_out("rst_hold", 4'b1000, 4'b1111, 0, 32'h0, 0, 32'h0, 5'd0);
    tick(); idle();
    expect_out("rst_release", 4'b0000, 4'b1111, 1, RPC, 0, 32'h0, 5'd0);
    tick(); idle();
    expect_out("run_idle", 4'b0000, 4'b0000, 0, 32'h0, 0, 32'h0, 5'd0);

    // Divider stall with a pending taken branch
    for (int i = 0; i < 32; i++) begin
      tick(); idle();
      alu_stall = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h2000;
      expect_out("div_stall", 4'b1110, 4'b0000, 0, 32'h0, 0, 32'h0, 5'd0);
    end
    tick(); idle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h2000;
    expect_out("div_done_branch", 4'b0000, 4'b1100, 1, 32'h2000, 0, 32'h0, 5'd0);
    tick(); idle();
    expect_out("after_branch", 4'b0000, 4'b0000, 0, 32'h0, 0, 32'h0, 5'd0);

    // Plain branch, hazard and mem stall chains
    tick(); idle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h1000;
    expect_out("branch", 4'b0000, 4'b1100, 1, 32'h1000, 0, 32'h0, 5'd0);
    tick(); idle(); id_hazard = 1'b1;
    expect_out("id_hazard", 4'b1100, 4'b0000, 0, 32'h0, 0, 32'h0, 5'd0);
    tick(); idle(); mem_busy = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h1234;
    expect_out("mem_busy_blocks_br", 4'b1111, 4'b0000, 0, 32'h0, 0, 32'h0, 5'd0);

    // Divide-by-zero with a 3-cycle drain
    tick(); idle(); ex_exc_div_by_zero = 1'b1; ex_pc = 32'h204;
    expect_out("divz_take", 4'b0000, 4'b1110, 0, 32'h0, 1, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); mem_busy = 1'b1; irq = (i == 1); ex_branch_taken = (i == 2);
      ex_branch_target = 32'h5555;
      expect_out("divz_drain", 4'b1111, 4'b1110, 0, 32'h0, 0, 32'h204, 5'd19);
    end
    tick(); idle();
    expect_out("divz_drain_done", 4'b0000, 4'b1110, 0, 32'h0, 0, 32'h204, 5'd19);
    tick(); idle();
    expect_out("divz_vector", 4'b0000, 4'b1110, 1, EV, 0, 32'h204, 5'd19);
    tick(); idle();
    expect_out("divz_run", 4'b0000, 4'b0000, 0, 32'h0, 0, 32'h204, 5'd19);

    // Simultaneous bus error, illegal, irq and branch: bus error wins
    tick(); idle();
    mem_exc_bus = 1'b1; mem_pc = 32'h100; ex_exc_illegal = 1'b1; ex_pc = 32'h104;
    irq = 1'b1; irq_num = 4'd5; ex_branch_taken = 1'b1; ex_branch_target = 32'h3000;
    expect_out("simul_take", 4'b0000, 4'b1111, 0, 32'h0, 1, 32'h204, 5'd19);
    tick(); idle();
    expect_out("simul_drain", 4'b0000, 4'b1110, 0, 32'h0, 0, 32'h100, 5'd16);
    tick(); idle();
    expect_out("simul_vector", 4'b0000, 4'b1110, 1, EV, 0, 32'h100, 5'd16);
    tick(); idle();
    expect_out("simul_run", 4'b0000, 4'b0000, 0, 32'h0, 0, 32'h100, 5'd16);

    // Illegal beats divide
    tick(); idle(); ex_exc_illegal = 1'b1; ex_exc_div_by_zero = 1'b1; ex_pc = 32'h300;
    expect_out("ill_take", 4'b0000, 4'b1110, 0, 32'h0, 1, 32'h100, 5'd16);
    tick(); idle();
    expect_out("ill_drain", 4'b0000, 4'b1110, 0, 32'h0, 0, 32'h300, 5'd17);
    tick(); idle();
    expect_out("ill_vector", 4'b0000, 4'b1110, 1, EV, 0, 32'h300, 5'd17);

    // Branch outranks irq; then irq alone
    tick(); idle(); ex_branch_taken = 1'b1; ex_branch_target = 32'h500; irq = 1'b1; irq_num = 4'd7;
    expect_out("br_over_irq", 4'b0000, 4'b1100, 1, 32'h500, 0, 32'h300, 5'd17);
    tick(); idle(); irq = 1'b1; irq_num = 4'd7; ex_pc = 32'h400;
    expect_out("irq_take", 4'b0000, 4'b1110, 0, 32'h0, 1, 32'h300, 5'd17);
    tick(); idle();
    expect_out("irq_drain", 4'b0000, 4'b1110, 0, 32'h0, 0, 32'h400, 5'd7);
    tick(); idle();
    expect_out("irq_vector", 4'b0000, 4'b1110, 1, EV, 0, 32'h400, 5'd7);
    tick(); idle();
    expect_out("irq_run", 4'b0000, 4'b0000, 0, 32'h0, 0, 32'h400, 5'd7);

    // Reset during DRAIN
    tick(); idle(); ex_exc_div_by_zero = 1'b1; ex_pc = 32'h600;
    expect_out("rd_take", 4'b0000, 4'b1110, 0, 32'h0, 1, 32'h400, 5'd7);
    tick(); idle(); mem_busy = 1'b1;
    expect_out("rd_drain", 4'b1111, 4'b1110, 0, 32'h0, 0, 32'h600, 5'd19);
    tick(); idle(); mem_busy = 1'b1; rst = 1'b0;
    expect_out("rd_assert", 4'b1111, 4'b1111, 0, 32'h0, 0, 32'h600, 5'd19);
    tick(); idle();
    expect_out("rd_release", 4'b0000, 4'b1111, 1, RPC, 0, 32'h0, 5'd0);
    tick(); idle();
    expect_out("rd_run", 4'b0000, 4'b0000, 0, 32'h0, 0, 32'h0, 5'd0);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
